ahb_lite_mem_slave: RTL

//  AHB-Lite single-port memory slave on HCLK/HRESETn: the DUT driven through the team's AHB-Lite interface.

---
 rtl/ahb_lite_mem_slave.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite single-port memory slave: pipelined address/data phases,
// programmable wait states, two-cycle ERROR response, little-endian lanes.
module ahb_lite_mem_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    wcnt, wcnt_nxt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic          pend_q;
    logic [31:0]   mem [MEM_WORDS];
    logic          accept;
    logic          illegal;
    logic          complete;
    logic [3:0]    be;
    logic          unused_ok;

    assign unused_ok = ^{HBURST, HPROT};

    assign accept  = HSEL && HREADY && HTRANS[1] &&
                     (state == ST_IDLE || state == ST_ERR2);
    assign illegal = (HSIZE > 3'd2) ||
                     (HADDR >= 32'(MEM_WORDS * 4)) ||
                     (HSIZE == 3'd1 && HADDR[0]) ||
                     (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

    // pend_q marks a legal data phase still owed; it completes once the FSM is back in IDLE
    assign complete = pend_q && (state == ST_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                addr_q  <= HADDR[AW+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
                pend_q  <= !illegal;
            end else if (complete) begin
                pend_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: begin
                if (complete && !write_q) begin
                    HRDATA = mem[addr_q[AW+1:2]];
                end
            end
        endcase
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be[addr_q[1:0]] = 1'b1;
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (complete && write_q) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (be[l]) begin
                    mem[addr_q[AW+1:2]][8*l +: 8] <= HWDATA[8*l +: 8];
                end
            end
        end
    end

endmodule
